// File: rtl/collect_uart_if.sv
// Byte-in / word-out handshake bundle between the UART receiver, collect_uart
// and the CORDIC input stage.
interface collect_uart_if #(
    parameter int DATA_WIDTH_IN  = 8,
    parameter int DATA_WIDTH_OUT = 40
);
    logic [DATA_WIDTH_IN-1:0]  i_data;
    logic                      i_data_valid;
    logic                      i_ready;
    logic [DATA_WIDTH_OUT-1:0] o_data;
    logic                      o_data_valid;
    logic                      o_busy;
    logic                      o_timeout;
    logic                      o_overrun;

    modport master (
        output i_data, i_data_valid, i_ready,
        input  o_data, o_data_valid, o_busy, o_timeout, o_overrun
    );

    modport slave (
        input  i_data, i_data_valid, i_ready,
        output o_data, o_data_valid, o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/collect_uart.sv
// Assembles MSB-first UART bytes into one operand word with a valid/ready
// hand-off, an inter-byte timeout and an overrun strobe.
module collect_uart #(
    parameter int DATA_WIDTH_IN  = 8,
    parameter int DATA_WIDTH_OUT = 40,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic           clk,
    input logic           rst,
    collect_uart_if.slave bus
);
    localparam int BYTES = DATA_WIDTH_OUT / DATA_WIDTH_IN;
    localparam int CNT_W = $clog2(BYTES);
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LOW_W = DATA_WIDTH_OUT - DATA_WIDTH_IN;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic [LOW_W-1:0]          sr;
    logic [LOW_W-1:0]          sr_next;
    logic [TMO_W-1:0]          tmo_cnt;
    logic [DATA_WIDTH_OUT-1:0] data_q;
    logic                      valid_q;
    logic                      timeout_q;
    logic                      overrun_q;

    // Only the low bytes are kept: the newest byte completes the word directly.
    assign sr_next = LOW_W'({sr, bus.i_data});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            sr        <= '0;
            tmo_cnt   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_data_valid) begin
                        sr      <= sr_next;
                        count   <= CNT_W'(1);
                        tmo_cnt <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.i_data_valid) begin
                        if (count == LAST_BYTE) begin
                            data_q  <= {sr, bus.i_data};
                            valid_q <= 1'b1;
                            count   <= '0;
                            state   <= HOLD;
                        end else begin
                            sr      <= sr_next;
                            count   <= count + 1'b1;
                            tmo_cnt <= '0;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) begin
                        count     <= '0;
                        sr        <= '0;
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        if (bus.i_data_valid) begin
                            sr      <= sr_next;
                            count   <= CNT_W'(1);
                            tmo_cnt <= '0;
                            state   <= COLLECT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.i_data_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_timeout    = timeout_q;
    assign bus.o_overrun    = overrun_q;
endmodule
